shift_sub_divider: RTL and testbench
====================================

Name: shift_sub_divider

Overview:
Sequential unsigned restoring divider, the inverse companion of the team's shift-add multiplier. It produces one quotient bit per clock by shift-left and trial-subtract. It sits beside the multiplier in the arithmetic unit, behind a start/busy/done handshake, and returns the quotient and remainder of an N-bit dividend by an N-bit divisor.

Parameters:
N, 8, operand, quotient and remainder width in bits (N >= 2).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
dividend  input  N  unsigned dividend; captured on the accepted start edge.
divisor  input  N  unsigned divisor; captured on the accepted start edge.
quotient  output  N  registered quotient; valid from the cycle done is high until the next accepted start.
remainder  output  N  registered remainder; same validity as quotient.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse while in the DONE state.
div_by_zero  output  1  registered flag; updated together with quotient and remainder.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state goes to IDLE; any operation in progress is aborted and no done is produced.
  - quotient, remainder, div_by_zero, busy and done all reset to 0.
  - internal A, Q, B registers and the iteration counter reset to 0.
- State IDLE:
  - busy=0, done=0.
  - If start=1 at an edge and divisor!=0: B<=divisor, Q<=dividend, A<=0, cnt<=N, go to RUN.
  - If start=1 at an edge and divisor==0: go straight to DONE. quotient<={N{1}}, remainder<=dividend, div_by_zero<=1.
- State RUN, one iteration per edge:
  - Shifted partial remainder P = {A, Q[N-1]} (N+1 bits).
  - T = P - {1'b0, B}, computed at N+1 bits.
  - If T[N]==0 (non-negative): A<=T[N-1:0], Q<={Q[N-2:0], 1'b1}.
  - Otherwise (restore): A<=P[N-1:0], Q<={Q[N-2:0], 1'b0}.
  - cnt<=cnt-1.
  - On the edge where cnt==1: also quotient<=next Q, remainder<=next A, div_by_zero<=0, go to DONE.
- State DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - start in DONE is ignored; it is not queued.
- Latency:
  - start accepted at edge t with nonzero divisor: done is high during the cycle after edge t+N, i.e. N+1 cycles including the accept edge.
  - Divide-by-zero: done is high in the cycle after edge t.
  - Throughput is one division per N+2 cycles.
- start while busy=1 is ignored. Operand changes after the accept edge have no effect.
- Outputs hold their last values in IDLE and RUN. They change only on entry to DONE, or on reset.
- Invariant checked by the bench for nonzero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.
- Edge cases:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - dividend == 0 gives 0, 0.
  - No overflow is possible for unsigned N/N division.

Test Plan:
- N=8: start with 100/7 -> done exactly 9 cycles after the accept edge; quotient=14, remainder=2, div_by_zero=0, busy high across the operation.
- Boundary values: 255/1 -> 255 r0; 255/255 -> 1 r0; 5/9 -> 0 r5; 0/13 -> 0 r0; 128/2 -> 64 r0.
- Divide by zero: 200/0 -> done in the cycle after accept, quotient=255, remainder=200, div_by_zero=1. A following 10/3 -> 3 r1 with div_by_zero cleared to 0.
- Handshake: start held high continuously -> accepted only in IDLE, one operation per 10 cycles, done pulses exactly 1 cycle each. Changing the operands mid-RUN does not alter the result.
- Reset: assert rst 4 cycles into 77/5 -> immediately busy=0, done=0, all outputs 0, no done pulse. A subsequent 77/5 -> 15 r2.
- Random: 1000 random operand pairs with nonzero divisor -> quotient and remainder match the reference model `/` and `%`, and the latency is always 9 cycles.

Source files
------------

// File: rtl/shift_sub_divider_if.sv
// Start/busy/done handshake and operand/result bus for the shift-subtract divider.
interface shift_sub_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock by shift-left
// and trial-subtract, behind a start/busy/done handshake.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    shift_sub_divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;

    logic [N:0]    w_p;
    logic [N:0]    w_t;
    logic [N-1:0]  w_a_next;
    logic [N-1:0]  w_q_next;

    // Trial subtract at N+1 bits; a set MSB means the divisor did not fit, so restore.
    always_comb begin
        w_p = {r_a, r_q[N-1]};
        w_t = w_p - {1'b0, r_b};
        if (!w_t[N]) begin
            w_a_next = w_t[N-1:0];
            w_q_next = {r_q[N-2:0], 1'b1};
        end else begin
            w_a_next = w_p[N-1:0];
            w_q_next = {r_q[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_b     <= bus.divisor;
                            r_q     <= bus.dividend;
                            r_a     <= '0;
                            r_cnt   <= CW'(N);
                            r_state <= S_RUN;
                        end else begin
                            r_quot  <= '1;
                            r_rem   <= bus.dividend;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_a_next;
                        r_dbz   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.done        = (r_state == S_DONE);
endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed scenarios plus random
// operands checked against plain '/' and '%' arithmetic.
module tb_shift_sub_divider;
    localparam int N       = 8;
    localparam int CYC_MAX = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    shift_sub_divider_if #(.N(N)) bus ();

    shift_sub_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: ordinary unsigned division, all-ones quotient on divide-by-zero.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = N'(int'(a) / int'(b)); r = N'(int'(a) % int'(b)); z = 1'b0;
        end
    endfunction

    // Called at posedge+1 with the DUT idle; lat counts edges from accept edge to done.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output bit busy_ok,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic z, output logic done_after);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < CYC_MAX) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.busy) busy_ok = 1'b0;
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #12;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
        vectors++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            miscompares++; $display("FAIL reset_outputs got q=%0d r=%0d z=%b want 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit bok; logic [N-1:0] q, r; logic z, da;
        run_div(8'd100, 8'd7, lat, bok, q, r, z, da);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL basic_latency got %0d want 9", lat); end
        vectors++; if (q !== 8'd14) begin miscompares++; $display("FAIL basic_quot got %0d want 14", q); end
        vectors++; if (r !== 8'd2) begin miscompares++; $display("FAIL basic_rem got %0d want 2", r); end
        vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL basic_dbz got %b want 0", z); end
        vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", bok); end
        vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %b want 0", da); end
    endtask

    task automatic test_boundary();
        logic [N-1:0] ta [5] = '{8'd255, 8'd255, 8'd5, 8'd0,  8'd128};
        logic [N-1:0] tb [5] = '{8'd1,   8'd255, 8'd9, 8'd13, 8'd2};
        logic [N-1:0] tq [5] = '{8'd255, 8'd1,   8'd0, 8'd0,  8'd64};
        logic [N-1:0] tr [5] = '{8'd0,   8'd0,   8'd5, 8'd0,  8'd0};
        int lat; bit bok; logic [N-1:0] q, r; logic z, da;
        for (int unsigned i = 0; i < 5; i++) begin
            run_div(ta[i], tb[i], lat, bok, q, r, z, da);
            vectors++; if (q !== tq[i] || r !== tr[i] || z !== 1'b0) begin miscompares++;
                $display("FAIL boundary_%0d/%0d got q=%0d r=%0d z=%b want %0d %0d 0", ta[i], tb[i], q, r, z, tq[i], tr[i]); end
            vectors++; if (lat !== 9) begin miscompares++; $display("FAIL boundary_latency got %0d want 9", lat); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat; bit bok; logic [N-1:0] q, r; logic z, da;
        run_div(8'd200, 8'd0, lat, bok, q, r, z, da);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL dbz_latency got %0d want 1", lat); end
        vectors++; if (q !== 8'd255 || r !== 8'd200) begin miscompares++; $display("FAIL dbz_result got q=%0d r=%0d want 255 200", q, r); end
        vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL dbz_flag got %b want 1", z); end
        vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL dbz_done_width got %b want 0", da); end
        run_div(8'd10, 8'd3, lat, bok, q, r, z, da);
        vectors++; if (q !== 8'd3 || r !== 8'd1 || z !== 1'b0) begin miscompares++;
            $display("FAIL dbz_followup got q=%0d r=%0d z=%b want 3 1 0", q, r, z); end
    endtask

    task automatic test_back_to_back();
        int t_done [$];
        logic prev = 1'b0;
        bit width_err = 1'b0;
        bus.dividend = 8'd50; bus.divisor = 8'd6; bus.start = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (prev) width_err = 1'b1;
                else t_done.push_back(c);
                vectors++; if (bus.quotient !== 8'd8 || bus.remainder !== 8'd2) begin miscompares++;
                    $display("FAIL b2b_result got q=%0d r=%0d want 8 2", bus.quotient, bus.remainder); end
            end
            prev = bus.done;
        end
        bus.start = 1'b0;
        vectors++; if (t_done.size() !== 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", t_done.size()); end
        vectors++; if (width_err !== 1'b0) begin miscompares++; $display("FAIL b2b_done_width got %b want 0", width_err); end
        if (t_done.size() == 3) begin
            vectors++; if (t_done[0] !== 9) begin miscompares++; $display("FAIL b2b_first got %0d want 9", t_done[0]); end
            vectors++; if (t_done[1] - t_done[0] !== 10 || t_done[2] - t_done[1] !== 10) begin miscompares++;
                $display("FAIL b2b_period got %0d,%0d want 10,10", t_done[1] - t_done[0], t_done[2] - t_done[1]); end
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_operand_change();
        int lat = 1;
        bus.dividend = 8'd200; bus.divisor = 8'd9; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!bus.done && lat < CYC_MAX) begin
            bus.dividend = N'($urandom);
            bus.divisor  = N'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (bus.quotient !== 8'd22 || bus.remainder !== 8'd2 || lat !== 9) begin miscompares++;
            $display("FAIL opchange got q=%0d r=%0d lat=%0d want 22 2 9", bus.quotient, bus.remainder, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; logic [N-1:0] q, r; logic z, da;
        int seen = 0;
        bus.dividend = 8'd77; bus.divisor = 8'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++;
            $display("FAIL midreset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        vectors++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin miscompares++;
            $display("FAIL midreset_outputs got q=%0d r=%0d z=%b want 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b0;
            if (bus.done) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
        run_div(8'd77, 8'd5, lat, bok, q, r, z, da);
        vectors++; if (q !== 8'd15 || r !== 8'd2 || lat !== 9) begin miscompares++;
            $display("FAIL midreset_rerun got q=%0d r=%0d lat=%0d want 15 2 9", q, r, lat); end
    endtask

    task automatic test_random();
        int lat; bit bok; logic [N-1:0] q, r, eq, er; logic z, ez, da;
        logic [N-1:0] a, b;
        for (int unsigned i = 0; i < 1000; i++) begin
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(1, 255));
            ref_div(a, b, eq, er, ez);
            run_div(a, b, lat, bok, q, r, z, da);
            vectors++; if (q !== eq || r !== er || z !== ez) begin miscompares++;
                $display("FAIL random_%0d/%0d got q=%0d r=%0d z=%b want %0d %0d %b", a, b, q, r, z, eq, er, ez); end
            vectors++; if (lat !== 9 || bok !== 1'b1 || da !== 1'b0) begin miscompares++;
                $display("FAIL random_timing got lat=%0d busy=%b done_after=%b want 9 1 0", lat, bok, da); end
            vectors++; if (int'(q) * int'(b) + int'(r) !== int'(a) || r >= b) begin miscompares++;
                $display("FAIL random_invariant got q=%0d r=%0d for %0d/%0d", q, r, a, b); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_by_zero();
        test_back_to_back();
        test_operand_change();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
